print_queue: RTL

Parametrised successor to the core's fixed 4-byte print path into a 512-entry byte ring.
- Accepts a word of WORD_W bits plus a byte count.
- Serialises the word MSB-first, one byte per cycle, into a DEPTH-byte ring buffer.
- Presents bytes to the UART transmitter over a valid/ready handshake.
- Uses all DEPTH slots, unlike the old one-slot-sacrifice full test. Reports occupancy and sticky error status.

---
 rtl/print_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/print_queue.sv
// print_queue: a word-to-byte print path. A word of WORD_W bits and a byte
// count are accepted and serialised one byte per cycle into a DEPTH-byte ring.
// The ring drains to a UART transmitter over a valid/ready handshake. All
// DEPTH slots are usable because occupancy is tracked in a separate counter
// rather than being derived from the pointers.
//
// Optional build macro: PRINT_QUEUE_LE_EN adds push_le. When push_le is 1,
// the low nbytes bytes are emitted least-significant byte first.
//
// Ports:
//   CLK           clock, rising edge
//   INITIALIZE_N  asynchronous active-low reset
//   push_valid    word offered
//   push_ready    serialiser idle, a word can be accepted
//   push_data     word to print
//   push_nbytes   bytes to emit (1..WB); 0 or >WB sets err and emits nothing
//   push_le       (PRINT_QUEUE_LE_EN only) emit low bytes LSB-first
//   tx_valid      a byte is available at the ring head
//   tx_ready      consumer takes the byte
//   tx_data       byte at the ring head
//   count         bytes stored, 0..DEPTH
//   full          count == DEPTH
//   empty         count == 0
//   err           sticky error flag, cleared only by reset
module print_queue #(
  parameter int  WORD_W = 32,
  parameter int  DEPTH  = 512,
  localparam int WB     = WORD_W / 8,
  localparam int NB_W   = $clog2(WB + 1),
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              INITIALIZE_N,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [WORD_W-1:0] push_data,
  input  logic [NB_W-1:0]   push_nbytes,
`ifdef PRINT_QUEUE_LE_EN
  input  logic              push_le,
`endif
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [NB_W-1:0]   rem;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] load_word;
  logic [7:0]        wr_byte;
  logic [7:0]        mem [DEPTH];
  logic              nb_ok, load, wr_en, rd_en;

  assign nb_ok = (push_nbytes != '0) && (push_nbytes <= NB_W'(WB));
  assign load  = push_ready && push_valid && nb_ok;
  assign rd_en = tx_valid && tx_ready;

  // Left-align the word so the top byte of the shifter is the first byte
  // out; the unused high bytes of push_data fall off the top.
  assign load_word = push_data << (8 * (WB - int'(push_nbytes)));

`ifdef PRINT_QUEUE_LE_EN
  logic le_q;
  assign wr_byte = le_q ? shift_q[7:0] : shift_q[WORD_W-1 -: 8];
`else
  assign wr_byte = shift_q[WORD_W-1 -: 8];
`endif

  // Serialiser state register
  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) state <= IDLE;
    else               state <= state_nxt;
  end

  // Serialiser next state; a full ring freezes SHIFT in place
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push_valid && nb_ok) state_nxt = SHIFT;
      SHIFT:   if (wr_en && rem == NB_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serialiser outputs; write gating uses the registered full flag
  always_comb begin
    push_ready = (state == IDLE);
    wr_en      = (state == SHIFT) && !full;
  end

  // Control: pointers, occupancy, remaining byte count, sticky error
  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rem    <= '0;
      err    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (load)       rem <= push_nbytes;
      else if (wr_en) rem <= rem - NB_W'(1);
      if (push_ready && push_valid && !nb_ok) err <= 1'b1;
    end
  end

  // Datapath: shifter and ring storage, not reset
  always_ff @(posedge CLK) begin
`ifdef PRINT_QUEUE_LE_EN
    if (load) begin
      le_q    <= push_le;
      shift_q <= push_le ? push_data : load_word;
    end else if (wr_en) begin
      shift_q <= le_q ? (shift_q >> 8) : (shift_q << 8);
    end
`else
    if (load)       shift_q <= load_word;
    else if (wr_en) shift_q <= shift_q << 8;
`endif
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  assign tx_data  = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = !empty;

endmodule
